jtdd_adpcm_romarb: RTL and testbench
====================================

// Module: jtdd_adpcm_romarb
// PURPOSE
//  Shares one ADPCM sample-ROM port between the two ADPCM voice channels (ch0, ch1).
//  Each channel requests a byte address. It sees an ok/data pair backed by a one-entry
//  per-channel cache, so the voices behave as if each owns the ROM.
//  Sits between the two ADPCM decoder blocks and the SDRAM ROM-request slot.
// PARAMETERS
//  AW   16  per-channel byte-address width; shared ROM address is AW+1 bits ({ch,addr})
//  DLY  1   cycles after a grant during which rom_ok is ignored (stale-ok guard), 0..3
//  TMO  255 cycles in WAIT without rom_ok before the fetch is aborted
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous reset, active low
//  ch_cs      in   2      per-channel request valid
//  ch0_addr   in   AW     ch0 byte address
//  ch1_addr   in   AW     ch1 byte address
//  ch0_data   out  8      ch0 cached byte
//  ch1_data   out  8      ch1 cached byte
//  ch_ok      out  2      per-channel: data valid for the current address
//  rom_addr   out  AW+1   shared ROM address, MSB = granted channel
//  rom_cs     out  1      shared ROM request
//  rom_data   in   8      shared ROM data
//  rom_ok     in   1      shared ROM data valid
//  err        out  1      sticky: a fetch timed out; cleared only by reset
// BEHAVIOUR
//  - Reset: rom_cs=0, rom_addr=0, ch*_data=0, cache valid=0 (so ch_ok=0), err=0.
//    FSM=IDLE, round-robin pointer favours ch0 first.
//  - Cache per channel i: {valid, tag[AW-1:0], data[7:0]}.
//    ch_ok[i] = ch_cs[i] & valid[i] & (tag[i]==chi_addr), combinational.
//    chi_data = data[i], registered.
//  - pend[i] = ch_cs[i] & ~ch_ok[i].
//  - FSM IDLE:
//    * If no pend, stay with rom_cs=0.
//    * If one pend, grant it.
//    * If both pend, grant the channel not granted last (round-robin).
//    * On grant edge: latch g and the address. rom_addr<={g,addr}, rom_cs<=1, wcnt<=0, go WAIT.
//  - FSM WAIT: rom_cs=1, rom_addr held stable. wcnt increments every cycle, saturating.
//    * rom_ok with wcnt<DLY: ignored.
//    * rom_ok with wcnt>=DLY: data[g]<=rom_data, tag[g]<=latched addr, valid[g]<=1.
//      Then rom_cs<=0, last<=g, go IDLE.
//    * wcnt==TMO with no rom_ok: err<=1, rom_cs<=0, last<=g, go IDLE. The cache is untouched.
//  - Latency: a miss raised in IDLE gives ch_ok high DLY+2 cycles after the request edge,
//    when rom_ok is already high. A hit gives ch_ok in the same cycle.
//    There is at least one IDLE cycle between fetches.
//  - Address change mid-fetch: the fetch completes and fills the cache with the old
//    address, so ch_ok stays 0 for the new address. The new address is re-requested
//    after IDLE.
//  - ch_cs dropped mid-fetch: the fetch completes and the cache is filled.
//    ch_ok stays 0 while ch_cs=0.
//  - Both channels with the same address: they are separate cache entries and
//    separate fetches, because the ROM bank bit differs.
//  - Async reset mid-WAIT: everything returns to reset values immediately.
//    The in-flight ROM result is discarded.
//  - Address arithmetic: no wrap logic here. The requester owns address increments.
// STRUCTURE
//  - No shared package. FSM state codes (IDLE=0, WAIT=1) are localparams.
//    The state register is 1 bit.
//  - One natural sub-module: jtdd_adpcm_cache1 (valid/tag/data register, hit compare,
//    fill strobe), instantiated twice. The arbiter FSM stays in this module.
// TESTING
//  - Reset, then ch_cs=01, ch0_addr=0x1234, rom_ok after 3 cycles with data 0xA5
//    -> rom_addr=0x01234, ch_ok[0] rises, ch0_data=0xA5.
//  - Both channels miss in the same cycle (0x0010 / 0x0020)
//    -> ch0 fetched first, then ch1 (rom_addr 0x10020). Next contention grants ch1 first.
//  - rom_ok held permanently high with DLY=1
//    -> the first cycle after grant is ignored and data is captured on the second WAIT cycle.
//  - ch0_addr changes 0x0100->0x0101 mid-WAIT
//    -> cache tag=0x0100, ch_ok[0]=0, then a second fetch of 0x0101 follows.
//  - rom_ok never asserts -> after TMO cycles: err=1, rom_cs=0, FSM back to IDLE.
//    The other channel's pending request is then served.
//  - rst_n pulsed low during WAIT -> rom_cs=0, ch_ok=00, err=0 within the same cycle.

Source files
------------

// File: rtl/jtdd_adpcm_cache1.sv
// One-entry ADPCM byte cache: valid/tag/data register with a combinational hit compare.
// A fill strobe overwrites the entry unconditionally.
module jtdd_adpcm_cache1 #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [7:0]    fill_data,
    output logic          ok,
    output logic [7:0]    data
);

    logic          valid;
    logic [AW-1:0] tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= 8'h00;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end
    end

    assign ok = cs & valid & (tag == addr);

endmodule

// File: rtl/jtdd_adpcm_romarb.sv
// Round-robin arbiter sharing one ADPCM sample-ROM port between two voice channels,
// each channel fronted by a one-entry cache so it sees a private ok/data pair.
module jtdd_adpcm_romarb #(
    parameter int AW  = 16,
    parameter int DLY = 1,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    ch_cs,
    input  logic [AW-1:0] ch0_addr,
    input  logic [AW-1:0] ch1_addr,
    output logic [7:0]    ch0_data,
    output logic [7:0]    ch1_data,
    output logic [1:0]    ch_ok,
    output logic [AW:0]   rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic          err
);

    localparam logic IDLE = 1'b0;
    localparam logic WAIT = 1'b1;
    localparam int   WW   = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic          state;
    logic          last;
    logic [WW-1:0] wcnt;
    logic [1:0]    pend;
    logic [1:0]    fill;
    logic          gnt;
    logic          g;
    logic          accept;
    logic [AW-1:0] req_addr;

    // The bank bit of the held ROM address doubles as the latched grant.
    assign g      = rom_addr[AW];
    assign pend   = ch_cs & ~ch_ok;
    assign accept = (state == WAIT) & rom_ok & (wcnt >= WW'(DLY));
    assign fill   = {accept & g, accept & ~g};

    always_comb begin
        gnt = ~last;
        if (pend == 2'b01)
            gnt = 1'b0;
        else if (pend == 2'b10)
            gnt = 1'b1;
        req_addr = gnt ? ch1_addr : ch0_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            wcnt     <= '0;
            last     <= 1'b1;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        rom_addr <= {gnt, req_addr};
                        rom_cs   <= 1'b1;
                        wcnt     <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt != '1)
                        wcnt <= wcnt + 1'b1;
                    // A usable rom_ok wins over a timeout landing on the same cycle.
                    if (accept) begin
                        rom_cs <= 1'b0;
                        last   <= g;
                        state  <= IDLE;
                    end else if (wcnt == WW'(TMO)) begin
                        err    <= 1'b1;
                        rom_cs <= 1'b0;
                        last   <= g;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    jtdd_adpcm_cache1 #(.AW(AW)) u_cache0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (ch_cs[0]),
        .addr      (ch0_addr),
        .fill      (fill[0]),
        .fill_addr (rom_addr[AW-1:0]),
        .fill_data (rom_data),
        .ok        (ch_ok[0]),
        .data      (ch0_data)
    );

    jtdd_adpcm_cache1 #(.AW(AW)) u_cache1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (ch_cs[1]),
        .addr      (ch1_addr),
        .fill      (fill[1]),
        .fill_addr (rom_addr[AW-1:0]),
        .fill_data (rom_data),
        .ok        (ch_ok[1]),
        .data      (ch1_data)
    );

endmodule

// File: tb/tb_jtdd_adpcm_romarb.sv
// Directed bench for the two-channel ADPCM ROM arbiter: fills, round-robin,
// stale-ok guard, mid-fetch address change, timeout and asynchronous reset.
module tb_jtdd_adpcm_romarb;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ch_cs;
    logic [AW-1:0] ch0_addr;
    logic [AW-1:0] ch1_addr;
    logic [7:0]    ch0_data;
    logic [7:0]    ch1_data;
    logic [1:0]    ch_ok;
    logic [AW:0]   rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic          err;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    jtdd_adpcm_romarb #(.AW(AW), .DLY(1), .TMO(255)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_cs    (ch_cs),
        .ch0_addr (ch0_addr),
        .ch1_addr (ch1_addr),
        .ch0_data (ch0_data),
        .ch1_data (ch1_data),
        .ch_ok    (ch_ok),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Raise rom_ok after lat negedges and hold it until the arbiter drops rom_cs.
    task automatic respond(input int lat, input logic [7:0] d, input string tag);
        int n;
        repeat (lat) @(negedge clk);
        rom_ok   = 1'b1;
        rom_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rom_cs && n < 600);
        rom_ok   = 1'b0;
        rom_data = 8'h00;
        check({tag, "_done"}, 32'(rom_cs), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ch_cs    = 2'b00;
        ch0_addr = '0;
        ch1_addr = '0;
        rom_data = 8'h00;
        rom_ok   = 1'b0;
        repeat (3) tick();
        check("rst_rom_cs",   32'(rom_cs),   32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_ch_ok",    32'(ch_ok),    32'd0);
        check("rst_ch0_data", 32'(ch0_data), 32'd0);
        check("rst_ch1_data", 32'(ch1_data), 32'd0);
        check("rst_err",      32'(err),      32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] contention from reset: ch0 first, then ch1");
        ch0_addr = 16'h0010;
        ch1_addr = 16'h0020;
        ch_cs    = 2'b11;
        tick();
        check("c1_rom_cs",   32'(rom_cs),   32'd1);
        check("c1_rom_addr", 32'(rom_addr), 32'h00010);
        check("c1_ok_miss",  32'(ch_ok),    32'd0);
        respond(1, 8'h11, "c1_ch0");
        check("c1_ok_ch0",   32'(ch_ok),    32'b01);
        check("c1_ch0_data", 32'(ch0_data), 32'h11);
        tick();
        check("c1_rom_cs2",  32'(rom_cs),   32'd1);
        check("c1_rom_addr2",32'(rom_addr), 32'h10020);
        respond(1, 8'h22, "c1_ch1");
        check("c1_ok_both",  32'(ch_ok),    32'b11);
        check("c1_ch1_data", 32'(ch1_data), 32'h22);

        $display("[TB] single ch0 fetch of 0x1234");
        ch_cs    = 2'b01;
        ch0_addr = 16'h1234;
        tick();
        check("s_rom_cs",    32'(rom_cs),   32'd1);
        check("s_rom_addr",  32'(rom_addr), 32'h01234);
        check("s_ok_miss",   32'(ch_ok),    32'd0);
        respond(2, 8'hA5, "s_ch0");
        check("s_ok",        32'(ch_ok),    32'b01);
        check("s_ch0_data",  32'(ch0_data), 32'hA5);

        $display("[TB] contention after ch0 served, same address on both channels");
        ch0_addr = 16'h0300;
        ch1_addr = 16'h0300;
        ch_cs    = 2'b11;
        tick();
        check("c2_rom_addr", 32'(rom_addr), 32'h10300);
        respond(1, 8'h33, "c2_ch1");
        check("c2_ok_ch1",   32'(ch_ok),    32'b10);
        check("c2_ch1_data", 32'(ch1_data), 32'h33);
        tick();
        check("c2_rom_cs2",  32'(rom_cs),   32'd1);
        check("c2_rom_addr2",32'(rom_addr), 32'h00300);
        respond(1, 8'h44, "c2_ch0");
        check("c2_ok_both",  32'(ch_ok),    32'b11);
        check("c2_ch0_data", 32'(ch0_data), 32'h44);
        check("c2_ch1_keep", 32'(ch1_data), 32'h33);

        $display("[TB] rom_ok stuck high: first WAIT cycle ignored");
        rom_ok   = 1'b1;
        rom_data = 8'h5C;
        ch_cs    = 2'b01;
        ch0_addr = 16'h0400;
        tick();
        check("h_rom_addr",  32'(rom_addr), 32'h00400);
        tick();
        check("h_rom_cs_w",  32'(rom_cs),   32'd1);
        check("h_ok_w",      32'(ch_ok),    32'd0);
        tick();
        check("h_ok",        32'(ch_ok),    32'b01);
        check("h_ch0_data",  32'(ch0_data), 32'h5C);
        check("h_rom_cs",    32'(rom_cs),   32'd0);
        rom_ok   = 1'b0;
        rom_data = 8'h00;

        $display("[TB] address change during WAIT");
        ch0_addr = 16'h0100;
        tick();
        check("a_rom_addr",  32'(rom_addr), 32'h00100);
        ch0_addr = 16'h0101;
        tick();
        rom_ok   = 1'b1;
        rom_data = 8'h61;
        tick();
        rom_ok   = 1'b0;
        rom_data = 8'h00;
        check("a_rom_cs",    32'(rom_cs),   32'd0);
        check("a_ok_stale",  32'(ch_ok),    32'd0);
        check("a_ch0_data",  32'(ch0_data), 32'h61);
        tick();
        check("a_rom_cs2",   32'(rom_cs),   32'd1);
        check("a_rom_addr2", 32'(rom_addr), 32'h00101);
        respond(1, 8'h62, "a_ch0");
        check("a_ok",        32'(ch_ok),    32'b01);
        check("a_ch0_data2", 32'(ch0_data), 32'h62);

        $display("[TB] timeout on ch1, then ch0 served");
        ch0_addr = 16'h0700;
        ch1_addr = 16'h0800;
        ch_cs    = 2'b11;
        tick();
        check("t_rom_addr",  32'(rom_addr), 32'h10800);
        repeat (255) tick();
        check("t_rom_cs_pre",32'(rom_cs),   32'd1);
        check("t_err_pre",   32'(err),      32'd0);
        tick();
        check("t_rom_cs",    32'(rom_cs),   32'd0);
        check("t_err",       32'(err),      32'd1);
        check("t_ok",        32'(ch_ok),    32'd0);
        tick();
        check("t_rom_cs2",   32'(rom_cs),   32'd1);
        check("t_rom_addr2", 32'(rom_addr), 32'h00700);
        respond(1, 8'h77, "t_ch0");
        check("t_ok2",       32'(ch_ok),    32'b01);
        check("t_ch0_data",  32'(ch0_data), 32'h77);
        check("t_err_sticky",32'(err),      32'd1);

        $display("[TB] asynchronous reset during WAIT");
        tick();
        check("r_rom_cs",    32'(rom_cs),   32'd1);
        check("r_rom_addr",  32'(rom_addr), 32'h10800);
        #2 rst_n = 1'b0;
        #1;
        check("r_rom_cs0",   32'(rom_cs),   32'd0);
        check("r_ok0",       32'(ch_ok),    32'd0);
        check("r_err0",      32'(err),      32'd0);
        check("r_rom_addr0", 32'(rom_addr), 32'd0);
        check("r_ch0_data0", 32'(ch0_data), 32'd0);
        ch_cs = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        check("r_idle_cs",   32'(rom_cs),   32'd0);
        check("r_idle_ok",   32'(ch_ok),    32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
